// File: rtl/snake_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Package : snake_pkg
//  Brief   : Shared board geometry, cell position type and food spawner states.
//  Rev     : 1.0  initial release
// ============================================================================
package snake_pkg;

   localparam int GRID_W_DEF = 24;
   localparam int GRID_H_DEF = 16;
   localparam int X_BITS     = 5;
   localparam int Y_BITS     = 4;

   typedef struct packed {
      logic [X_BITS-1:0] x;
      logic [Y_BITS-1:0] y;
   } pos_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAMPLE = 3'd1,
      ST_QUERY  = 3'd2,
      ST_SCAN   = 3'd3,
      ST_DONE   = 3'd4
   } spawn_state_t;

endpackage
`default_nettype wire

// File: rtl/grid_pos_succ.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : grid_pos_succ
//  Brief   : Next cell in raster order; wraps at the row end and at the
//            bottom-right corner back to (0,0).
//  Rev     : 1.0  initial release
// ============================================================================
module grid_pos_succ
   import snake_pkg::*;
#(
   parameter int GRID_W = GRID_W_DEF,
   parameter int GRID_H = GRID_H_DEF
) (
   input  pos_t i_pos,
   output pos_t o_pos
);

   // Raster-order successor with row and board wrap
   always_comb begin
      o_pos = i_pos;
      if (i_pos.x == X_BITS'(GRID_W - 1)) begin
         o_pos.x = '0;
         if (i_pos.y == Y_BITS'(GRID_H - 1)) begin
            o_pos.y = '0;
         end else begin
            o_pos.y = i_pos.y + 1'b1;
         end
      end else begin
         o_pos.x = i_pos.x + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/food_spawner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : food_spawner
//  Brief   : Turns LFSR samples into a free food cell. Random draws are
//            checked against the snake body store; after MAX_TRIES failed
//            draws a linear scan from the last candidate takes over.
//  Rev     : 1.0  initial release
// ============================================================================
module food_spawner
   import snake_pkg::*;
#(
   parameter int GRID_W    = GRID_W_DEF,
   parameter int GRID_H    = GRID_H_DEF,
   parameter int MAX_TRIES = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [8:0]        i_rng,
   input  logic              i_req,
   output logic              o_busy,
   output logic              o_done,
   output logic [X_BITS-1:0] o_food_x,
   output logic [Y_BITS-1:0] o_food_y,
   output logic              o_full,
   output logic              o_q_valid,
   output logic [X_BITS-1:0] o_q_x,
   output logic [Y_BITS-1:0] o_q_y,
   input  logic              i_q_done,
   input  logic              i_q_hit
);

   localparam int c_TW        = $clog2(MAX_TRIES + 1);
   localparam int c_SCAN_LAST = GRID_W * GRID_H - 1;

   spawn_state_t    r_state;
   pos_t            r_cand;
   logic [c_TW-1:0] r_tries;
   logic [8:0]      r_scan_cnt;

   pos_t            w_rng_pos;
   logic            w_rng_ok;
   pos_t            w_succ_in;
   pos_t            w_succ;
   logic [c_TW-1:0] w_tries_inc;
   logic            w_tries_last;

   assign w_rng_pos    = '{x: i_rng[8:4], y: i_rng[3:0]};
   assign w_rng_ok     = ({1'b0, w_rng_pos.x} < 6'(GRID_W));
   assign w_tries_inc  = r_tries + 1'b1;
   assign w_tries_last = (w_tries_inc == c_TW'(MAX_TRIES));

   // Scan entry from SAMPLE only happens on a range reject, so the rejected
   // draw is folded to column 0 of its row before stepping forward.
   assign w_succ_in = (r_state == ST_SAMPLE) ? '{x: '0, y: w_rng_pos.y} : r_cand;

   grid_pos_succ #(
      .GRID_W (GRID_W),
      .GRID_H (GRID_H)
   ) u_succ (
      .i_pos (w_succ_in),
      .o_pos (w_succ)
   );

   // The query address is the candidate register itself, so it can only
   // move on the edge that consumes i_q_done.
   assign o_q_x = r_cand.x;
   assign o_q_y = r_cand.y;

   // Spawn control FSM with registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cand     <= '0;
         r_tries    <= '0;
         r_scan_cnt <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_food_x   <= '0;
         o_food_y   <= '0;
         o_full     <= 1'b0;
         o_q_valid  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_req) begin
                  r_tries <= '0;
                  o_full  <= 1'b0;
                  o_busy  <= 1'b1;
                  r_state <= ST_SAMPLE;
               end
            end

            ST_SAMPLE: begin
               r_cand <= w_rng_pos;
               if (!w_rng_ok) begin
                  r_tries <= w_tries_inc;
                  if (w_tries_last) begin
                     r_cand     <= w_succ;
                     r_scan_cnt <= '0;
                     o_q_valid  <= 1'b1;
                     r_state    <= ST_SCAN;
                  end
               end else begin
                  o_q_valid <= 1'b1;
                  r_state   <= ST_QUERY;
               end
            end

            ST_QUERY: begin
               if (i_q_done) begin
                  if (!i_q_hit) begin
                     o_q_valid <= 1'b0;
                     o_done    <= 1'b1;
                     o_food_x  <= r_cand.x;
                     o_food_y  <= r_cand.y;
                     r_state   <= ST_DONE;
                  end else begin
                     r_tries <= w_tries_inc;
                     if (w_tries_last) begin
                        r_cand     <= w_succ;
                        r_scan_cnt <= '0;
                        r_state    <= ST_SCAN;
                     end else begin
                        o_q_valid <= 1'b0;
                        r_state   <= ST_SAMPLE;
                     end
                  end
               end
            end

            ST_SCAN: begin
               if (i_q_done) begin
                  if (!i_q_hit) begin
                     o_q_valid <= 1'b0;
                     o_done    <= 1'b1;
                     o_food_x  <= r_cand.x;
                     o_food_y  <= r_cand.y;
                     r_state   <= ST_DONE;
                  end else if (r_scan_cnt == 9'(c_SCAN_LAST)) begin
                     o_q_valid <= 1'b0;
                     o_done    <= 1'b1;
                     o_full    <= 1'b1;
                     r_state   <= ST_DONE;
                  end else begin
                     r_cand     <= w_succ;
                     r_scan_cnt <= r_scan_cnt + 1'b1;
                  end
               end
            end

            ST_DONE: begin
               o_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_food_spawner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_food_spawner
//  Brief   : Directed self-checking bench for food_spawner.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_food_spawner;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] i_rng;
   logic       i_req;
   logic       o_busy;
   logic       o_done;
   logic [4:0] o_food_x;
   logic [3:0] o_food_y;
   logic       o_full;
   logic       o_q_valid;
   logic [4:0] o_q_x;
   logic [3:0] o_q_y;
   logic       i_q_done;
   logic       i_q_hit;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   food_spawner #(
      .GRID_W    (24),
      .GRID_H    (16),
      .MAX_TRIES (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_rng     (i_rng),
      .i_req     (i_req),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_food_x  (o_food_x),
      .o_food_y  (o_food_y),
      .o_full    (o_full),
      .o_q_valid (o_q_valid),
      .o_q_x     (o_q_x),
      .o_q_y     (o_q_y),
      .i_q_done  (i_q_done),
      .i_q_hit   (i_q_hit)
   );

   always #5 clk = ~clk;

   // Advance to the next falling edge and tally o_done pulses seen there
   task automatic tick();
      @(negedge clk);
      if (o_done) n_done++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int d0;
      int n;
      int guard;
      logic [4:0] lx;
      logic [3:0] ly;

      rst      = 1'b1;
      i_req    = 1'b0;
      i_rng    = '0;
      i_q_done = 1'b0;
      i_q_hit  = 1'b0;
      lx       = '0;
      ly       = '0;
      tick(); tick(); tick();

      // Reset state
      chk("rst_busy",  o_busy,    0);
      chk("rst_done",  o_done,    0);
      chk("rst_qv",    o_q_valid, 0);
      chk("rst_full",  o_full,    0);
      chk("rst_food",  {o_food_x, o_food_y}, 0);
      rst = 1'b0;
      tick();

      // 1: reset while a query is outstanding
      i_req = 1'b1; i_rng = 9'h0A3;
      tick();
      i_req = 1'b0;
      tick();
      chk("t1_qv_pre", o_q_valid, 1);
      rst = 1'b1;
      tick();
      chk("t1_qv",   o_q_valid, 0);
      chk("t1_busy", o_busy,    0);
      rst = 1'b0;
      tick(); tick(); tick();
      chk("t1_no_done", n_done, 0);
      chk("t1_food_x",  o_food_x, 0);
      chk("t1_food_y",  o_food_y, 0);
      chk("t1_busy2",   o_busy,   0);

      // 2: single draw, immediate miss; o_done at t+3
      i_req = 1'b1; i_rng = 9'h0A3;
      tick();
      i_req = 1'b0;
      chk("t2_busy_t1", o_busy,    1);
      chk("t2_qv_t1",   o_q_valid, 0);
      tick();
      chk("t2_qv_t2", o_q_valid, 1);
      chk("t2_qx",    o_q_x,     10);
      chk("t2_qy",    o_q_y,     3);
      chk("t2_done_t2", o_done,  0);
      i_q_done = 1'b1; i_q_hit = 1'b0;
      tick();
      i_q_done = 1'b0;
      chk("t2_done_t3", o_done,   1);
      chk("t2_food_x",  o_food_x, 10);
      chk("t2_food_y",  o_food_y, 3);
      chk("t2_full",    o_full,   0);
      chk("t2_busy_t3", o_busy,   1);
      chk("t2_qv_t3",   o_q_valid, 0);
      tick();
      chk("t2_done_t4", o_done, 0);
      chk("t2_busy_t4", o_busy, 0);

      // 3: out-of-range column rejected, second draw accepted
      i_req = 1'b1; i_rng = 9'h1E5;
      tick();
      i_req = 1'b0;
      tick();
      chk("t3_qv_rej", o_q_valid, 0);
      i_rng = 9'h052;
      tick();
      chk("t3_qv", o_q_valid, 1);
      chk("t3_qx", o_q_x,     5);
      chk("t3_qy", o_q_y,     2);
      i_q_done = 1'b1; i_q_hit = 1'b0;
      tick();
      i_q_done = 1'b0;
      chk("t3_done",   o_done,   1);
      chk("t3_food_x", o_food_x, 5);
      chk("t3_food_y", o_food_y, 2);
      tick();

      // 4: eight random hits, last at (23,3); scan visits (0,4) then (1,4)
      i_req = 1'b1;
      tick();
      i_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         i_rng = (i == 7) ? 9'h173 : {5'(i), 4'(i)};
         tick();
         chk("t4_rand_qx", o_q_x, (i == 7) ? 23 : i);
         i_q_done = 1'b1; i_q_hit = 1'b1;
         tick();
         i_q_done = 1'b0; i_q_hit = 1'b0;
      end
      chk("t4_scan_qv", o_q_valid, 1);
      chk("t4_scan0_x", o_q_x, 0);
      chk("t4_scan0_y", o_q_y, 4);
      i_q_done = 1'b1; i_q_hit = 1'b1;
      tick();
      chk("t4_scan1_x",  o_q_x, 1);
      chk("t4_scan1_y",  o_q_y, 4);
      chk("t4_scan1_qv", o_q_valid, 1);
      i_q_hit = 1'b0;
      tick();
      i_q_done = 1'b0;
      chk("t4_done",   o_done,   1);
      chk("t4_food_x", o_food_x, 1);
      chk("t4_food_y", o_food_y, 4);
      chk("t4_full",   o_full,   0);
      tick();
      chk("t4_busy", o_busy, 0);

      // 5: every query hits -> board full; next request clears o_full
      i_req = 1'b1;
      tick();
      i_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         i_rng = {5'(i + 2), 4'(i)};
         tick();
         chk("t5_rand_qx", o_q_x, i + 2);
         i_q_done = 1'b1; i_q_hit = 1'b1;
         tick();
         i_q_done = 1'b0; i_q_hit = 1'b0;
      end
      chk("t5_scan0_x", o_q_x, 10);
      chk("t5_scan0_y", o_q_y, 7);
      i_q_done = 1'b1; i_q_hit = 1'b1;
      n = 0;
      guard = 0;
      while (!o_done && guard < 1000) begin
         if (o_q_valid) begin
            n++;
            lx = o_q_x;
            ly = o_q_y;
         end
         guard++;
         tick();
      end
      i_q_done = 1'b0; i_q_hit = 1'b0;
      chk("t5_scan_cnt", n,        384);
      chk("t5_last_x",   lx,       9);
      chk("t5_last_y",   ly,       7);
      chk("t5_done",     o_done,   1);
      chk("t5_full",     o_full,   1);
      chk("t5_food_x",   o_food_x, 1);
      chk("t5_food_y",   o_food_y, 4);
      tick();
      chk("t5_busy_end", o_busy, 0);
      chk("t5_full_hold", o_full, 1);
      i_req = 1'b1; i_rng = 9'h0A3;
      tick();
      i_req = 1'b0;
      chk("t5_full_clr", o_full, 0);
      tick();
      chk("t5_re_qx", o_q_x, 10);
      i_q_done = 1'b1; i_q_hit = 1'b0;
      tick();
      i_q_done = 1'b0;
      chk("t5_re_done",   o_done,   1);
      chk("t5_re_food_x", o_food_x, 10);
      chk("t5_re_food_y", o_food_y, 3);
      tick();

      // 6: requests while busy ignored; slow query answer
      d0 = n_done;
      i_req = 1'b1; i_rng = 9'h119;
      tick();
      tick();
      i_req = 1'b0;
      chk("t6_qx", o_q_x, 17);
      chk("t6_qy", o_q_y, 9);
      for (int k = 0; k < 5; k++) begin
         i_req = (k == 2);
         tick();
         chk("t6_hold_qv", o_q_valid, 1);
         chk("t6_hold_qx", o_q_x,     17);
         chk("t6_hold_qy", o_q_y,     9);
      end
      i_req = 1'b0;
      i_q_done = 1'b1; i_q_hit = 1'b0;
      tick();
      i_q_done = 1'b0;
      chk("t6_done",   o_done,   1);
      chk("t6_food_x", o_food_x, 17);
      chk("t6_food_y", o_food_y, 9);
      tick(); tick(); tick();
      chk("t6_one_done", n_done - d0, 1);
      chk("t6_busy",     o_busy,      0);
      chk("t6_qv",       o_q_valid,   0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
